// File: rtl/uart_pkg.sv
// Shared UART package: data width and the TX arbiter state encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the search starts one past the last grant and
// returns the first set request as a one-hot vector plus its index.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]     start;
  logic [2*NUM_REQ-1:0] dbl;
  logic [IDX_W:0]       sum;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    start   = (last >= IDX_W'(NUM_REQ - 1)) ? '0 : last + 1'b1;
    dbl     = {req, req} >> start;
    any     = 1'b0;
    sum     = '0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && dbl[k]) begin
        any = 1'b1;
        sum = {1'b0, start} + (IDX_W + 1)'(k);
      end
    end
    // The rotated offset may run past the top requester; fold it back.
    if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
      sum = sum - (IDX_W + 1)'(NUM_REQ);
    end
    gnt_idx = sum[IDX_W-1:0];
    if (any) begin
      gnt = NUM_REQ'(1) << gnt_idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX serializer between NUM_REQ byte requesters.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int BUSY_TMO = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           active,
  output logic                           err_tmo,
  output logic [15:0]                    tx_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(BUSY_TMO + 1);

  arb_state_e             state_q,    state_d;
  logic [NUM_REQ-1:0]     req_ack_q,  req_ack_d;
  logic                   tx_start_q, tx_start_d;
  logic [UART_DATA_W-1:0] tx_data_q,  tx_data_d;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d;
  logic                   err_tmo_q,  err_tmo_d;
  logic [15:0]            tx_count_q, tx_count_d;
  logic [TMO_W-1:0]       tmo_cnt_q,  tmo_cnt_d;

  logic [IDX_W-1:0]       pick_last;
  logic [NUM_REQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  // Pretending the top requester was served last makes the search always begin at index 0.
  assign pick_last = IDX_W'(NUM_REQ - 1);
`else
  assign pick_last = grant_id_q;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req     (req_valid),
    .last    (pick_last),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    req_ack_d  = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    err_tmo_d  = err_tmo_q;
    tx_count_d = tx_count_q;
    tmo_cnt_d  = tmo_cnt_q;
    case (state_q)
      ARB: begin
        // Ack and start are raised together so both are seen during the START cycle.
        if (pick_any && !tx_busy) begin
          req_ack_d  = pick_gnt;
          tx_start_d = 1'b1;
          tx_data_d  = req_data[UART_DATA_W*int'(pick_idx) +: UART_DATA_W];
          grant_id_d = pick_idx;
          state_d    = START;
        end
      end
      START: begin
        tmo_cnt_d = '0;
        state_d   = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (tmo_cnt_q == TMO_W'(BUSY_TMO - 1)) begin
          err_tmo_d = 1'b1;
          state_d   = ARB;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          tx_count_d = tx_count_q + 16'd1;
          state_d    = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      req_ack_q  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_id_q <= IDX_W'(NUM_REQ - 1);
      err_tmo_q  <= 1'b0;
      tx_count_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q    <= state_d;
      req_ack_q  <= req_ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      err_tmo_q  <= err_tmo_d;
      tx_count_q <= tx_count_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign req_ack  = req_ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign active   = (state_q != ARB);
  assign err_tmo  = err_tmo_q;
  assign tx_count = tx_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a behavioural UART_TX plus a line receiver;
// expected grants and serial bytes are queued by the stimulus and popped by monitors.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int BUSY_TMO = 7;
  localparam int BIT_CYC  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [31:0]  req_data;
  logic [3:0]   req_ack;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_busy;
  logic [1:0]   grant_id;
  logic         active;
  logic         err_tmo;
  logic [15:0]  tx_count;

  logic uart_en;
  logic ext_busy;
  logic m_busy;
  logic m_line;
  int   m_bit;
  int   m_cyc;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t       ack_q[$];
  logic [7:0] ser_q[$];
  exp_t       mon_e;
  logic       prev_start;

  logic       rx_act;
  int         rx_cnt;
  logic [7:0] rx_byte;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .BUSY_TMO (BUSY_TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active),
    .err_tmo   (err_tmo),
    .tx_count  (tx_count)
  );

  assign tx_busy = m_busy | ext_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART_TX model: start bit, 8 data bits LSB first read live from tx_data, stop bit.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_line <= 1'b1;
      m_bit  <= 0;
      m_cyc  <= 0;
    end else if (!m_busy) begin
      if (uart_en && tx_start) begin
        m_busy <= 1'b1;
        m_line <= 1'b0;
        m_bit  <= 0;
        m_cyc  <= 0;
      end
    end else if (m_cyc != BIT_CYC - 1) begin
      m_cyc <= m_cyc + 1;
    end else begin
      m_cyc <= 0;
      if (m_bit == 9) begin
        m_busy <= 1'b0;
        m_line <= 1'b1;
      end else begin
        m_bit  <= m_bit + 1;
        m_line <= (m_bit < 8) ? tx_data[m_bit] : 1'b1;
      end
    end
  end

  // Grant monitor.
  always @(negedge clk) begin
    if (!rst && (tx_start || req_ack != '0)) begin
      if (ack_q.size() == 0) begin
        check("unexpected_grant", 32'(ack_q.size()), 32'd1);
      end else begin
        mon_e = ack_q.pop_front();
        check("req_ack", 32'(req_ack), 32'(4'b0001 << mon_e.idx));
        check("tx_start", 32'(tx_start), 32'd1);
        check("tx_start_width", 32'(prev_start), 32'd0);
        check("grant_id", 32'(grant_id), 32'(mon_e.idx));
        check("tx_data", 32'(tx_data), 32'(mon_e.data));
      end
    end
    prev_start <= tx_start;
  end

  // Serial line receiver, samples the middle of each bit.
  always @(negedge clk) begin
    if (rst) begin
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (!m_line) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % BIT_CYC == BIT_CYC / 2) begin
        if (rx_cnt / BIT_CYC >= 1 && rx_cnt / BIT_CYC <= 8) begin
          rx_byte[rx_cnt/BIT_CYC-1] <= m_line;
        end else if (rx_cnt / BIT_CYC == 9) begin
          check("stop_bit", 32'(m_line), 32'd1);
          if (ser_q.size() == 0) check("unexpected_frame", 32'(ser_q.size()), 32'd1);
          else check("serial_byte", 32'(rx_byte), 32'(ser_q.pop_front()));
          rx_act <= 1'b0;
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_req_ack"},  32'(req_ack),  32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"},  32'(tx_data),  32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd3);
    check({tag, "_active"},   32'(active),   32'd0);
    check({tag, "_err_tmo"},  32'(err_tmo),  32'd0);
    check({tag, "_tx_count"}, 32'(tx_count), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    uart_en   = 1'b1;
    ext_busy  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset(tag);
    rst = 1'b0;
  endtask

  task automatic push(input logic [1:0] idx, input logic [7:0] data, input bit serial);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    ack_q.push_back(e);
    if (serial) ser_q.push_back(data);
  endtask

  task automatic wait_ack(input string name);
    int cyc = 0;
    @(negedge clk);
    while (req_ack == '0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_ack_seen"}, 32'(req_ack != '0), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while ((active || tx_busy || rx_act) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_idle"}, 32'({active, tx_busy, rx_act}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d0;
    logic [3:0] seen;
    int         cyc;
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    uart_en    = 1'b1;
    ext_busy   = 1'b0;
    prev_start = 1'b0;
    rx_act     = 1'b0;
    rx_cnt     = 0;
    rx_byte    = '0;

    // 1: single requester 2, byte 0xA5.
    do_reset("t1_reset");
    push(2'd2, 8'hA5, 1'b1);
    req_data[23:16] = 8'hA5;
    req_valid       = 4'b0100;
    wait_ack("t1");
    req_valid = '0;
    wait_idle("t1");
    check("t1_tx_count", 32'(tx_count), 32'd1);

    // 2: all four valid continuously -> rotation 0,1,2,3,0.
    do_reset("t2_reset");
    req_data = 32'h44332211;
    for (int n = 0; n < 5; n++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      push(2'd0, 8'h11, 1'b1);
`else
      push(2'(n % 4), 8'(8'h11 * ((n % 4) + 1)), 1'b1);
`endif
    end
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) wait_ack("t2");
    req_valid = '0;
    wait_idle("t2");
    check("t2_tx_count", 32'(tx_count), 32'd5);

    // 3: requesters 0 and 3; requester 0 refreshes its byte after each ack.
    do_reset("t3_reset");
    d0       = 8'h50;
    req_data = {8'hC3, 16'h0000, d0};
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    push(2'd0, 8'h50, 1'b1);
    push(2'd0, 8'h51, 1'b1);
    push(2'd0, 8'h52, 1'b1);
`else
    push(2'd0, 8'h50, 1'b1);
    push(2'd3, 8'hC3, 1'b1);
    push(2'd0, 8'h51, 1'b1);
`endif
    req_valid = 4'b1001;
    for (int n = 0; n < 3; n++) begin
      wait_ack("t3");
      if (req_ack[0]) begin
        d0            = d0 + 8'd1;
        req_data[7:0] = d0;
      end
    end
    req_valid = '0;
    wait_idle("t3");
    check("t3_tx_count", 32'(tx_count), 32'd3);

    // 4: UART never answers -> err_tmo exactly BUSY_TMO cycles after WAIT_HI entry.
    do_reset("t4_reset");
    uart_en = 1'b0;
    push(2'd1, 8'h3C, 1'b0);
    req_data[15:8] = 8'h3C;
    req_valid      = 4'b0010;
    wait_ack("t4");
    req_valid = '0;
    repeat (BUSY_TMO) @(negedge clk);
    check("t4_err_before", 32'(err_tmo), 32'd0);
    check("t4_active_before", 32'(active), 32'd1);
    @(negedge clk);
    check("t4_err_at_tmo", 32'(err_tmo), 32'd1);
    check("t4_active_at_tmo", 32'(active), 32'd0);
    check("t4_tx_count", 32'(tx_count), 32'd0);
    uart_en = 1'b1;
    push(2'd2, 8'h5A, 1'b1);
    req_data[23:16] = 8'h5A;
    req_valid       = 4'b0100;
    wait_ack("t4b");
    req_valid = '0;
    wait_idle("t4b");
    check("t4_err_sticky", 32'(err_tmo), 32'd1);
    check("t4b_tx_count", 32'(tx_count), 32'd1);

    // 5: external tx_busy blocks grants; ack the cycle after it falls.
    do_reset("t5_reset");
    push(2'd1, 8'h96, 1'b1);
    ext_busy       = 1'b1;
    req_data[15:8] = 8'h96;
    req_valid      = 4'b0010;
    seen           = '0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | req_ack | {3'b000, active};
    end
    check("t5_no_grant_while_busy", 32'(seen), 32'd0);
    ext_busy = 1'b0;
    @(negedge clk);
    check("t5_ack_after_release", 32'(req_ack), 32'd2);
    req_valid = '0;
    wait_idle("t5");
    check("t5_tx_count", 32'(tx_count), 32'd1);

    // 6: reset during WAIT_LO.
    do_reset("t6_reset");
    push(2'd3, 8'hE7, 1'b0);
    req_data[31:24] = 8'hE7;
    req_valid       = 4'b1000;
    wait_ack("t6");
    req_valid = '0;
    cyc = 0;
    while (!tx_busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check("t6_mid_frame_active", 32'(active), 32'd1);
    rst = 1'b1;
    #1;
    check_reset("t6_mid_rst");
    req_valid = 4'b1000;
    seen      = '0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | req_ack | {3'b000, tx_start};
    end
    check("t6_quiet_in_reset", 32'(seen), 32'd0);
    push(2'd3, 8'hE7, 1'b1);
    rst = 1'b0;
    wait_ack("t6b");
    req_valid = '0;
    wait_idle("t6b");
    check("t6_tx_count", 32'(tx_count), 32'd1);

    repeat (5) @(negedge clk);
    check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    check("serial_queue_drained", 32'(ser_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
